// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor with valid/ready word handshakes
// Optional signed-overflow output V is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             AV,
    output logic             AR,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             DV,
    input  logic             DR
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]   cnt;
    logic            bor;
    logic            d_bit;
    logic            bor_nx;
    logic            last_bit;

    // Single full-subtractor cell operating on the current LSBs
    assign d_bit    = a_sh[0] ^ b_sh[0] ^ bor;
    assign bor_nx   = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & bor) | (b_sh[0] & bor);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign AR = (state == IDLE);
    assign DV = (state == DONE);

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (AV) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    if (DR) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            bor  <= 1'b0;
            D    <= '0;
            BO   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            V    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (AV) begin
                        a_sh <= A;
                        b_sh <= B;
                        cnt  <= '0;
                        bor  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    D    <= {d_bit, D[WIDTH-1:1]};
                    bor  <= bor_nx;
                    if (last_bit) begin
                        BO <= bor_nx;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the LSBs are the operand sign bits
                        V  <= (a_sh[0] != b_sh[0]) & (d_bit != a_sh[0]);
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
